// File: rtl/sobel_window_gen_if.sv
// Pixel-stream interface between the raster source, sobel_window_gen and the
// Sobel stage. The master side drives raster pixels and consumes windows; the
// slave side (sobel_window_gen) does the opposite.
// Optional signal o_frame_done exists only when SOBEL_WIN_FRAME_DONE_EN is defined.
interface sobel_window_gen_if;
    logic [7:0]  i_pixel;
    logic        i_pixel_valid;
    logic        i_sof;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
`ifdef SOBEL_WIN_FRAME_DONE_EN
    logic        o_frame_done;

    modport master (
        output i_pixel, i_pixel_valid, i_sof,
        input  o_pixel_data, o_pixel_data_valid, o_frame_done
    );

    modport slave (
        input  i_pixel, i_pixel_valid, i_sof,
        output o_pixel_data, o_pixel_data_valid, o_frame_done
    );
`else
    modport master (
        output i_pixel, i_pixel_valid, i_sof,
        input  o_pixel_data, o_pixel_data_valid
    );

    modport slave (
        input  i_pixel, i_pixel_valid, i_sof,
        output o_pixel_data, o_pixel_data_valid
    );
`endif
endinterface

// File: rtl/sobel_window_gen.sv
// Raster-to-3x3-window generator feeding the Sobel edge detector.
// Buffers the two previous lines and emits one packed 72-bit neighbourhood
// (byte k = 3*dr + dc, bits [7:0] top-left, bits [71:64] current pixel) for
// every accepted pixel at row>=2, col>=2.
// Optional feature macro: SOBEL_WIN_FRAME_DONE_EN (adds o_frame_done pulse).
module sobel_window_gen #(
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 512
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    sobel_window_gen_if.slave  s_if
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Registers
    state_t             r_state;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [71:0]        r_win;
    logic               r_win_valid;
    logic [7:0]         r_lb_top [IMG_WIDTH];
    logic [7:0]         r_lb_mid [IMG_WIDTH];
`ifdef SOBEL_WIN_FRAME_DONE_EN
    logic               r_frame_done;
`endif

    // Combinational helpers
    logic               w_accept;
    logic               w_sof;
    logic [COL_W-1:0]   w_col;
    logic [ROW_W-1:0]   w_row;
    logic               w_col_last;
    logic               w_row_last;
    logic [COL_W-1:0]   w_col_next;
    logic [ROW_W-1:0]   w_row_next;
    logic [7:0]         w_top;
    logic [7:0]         w_mid;
    logic [71:0]        w_win_next;
    logic               w_win_valid;
    state_t             w_state_next;

    // A sof accept is treated as pixel (0,0) regardless of the running counters
    assign w_accept   = s_if.i_pixel_valid;
    assign w_sof      = s_if.i_pixel_valid & s_if.i_sof;
    assign w_col      = w_sof ? '0 : r_col;
    assign w_row      = w_sof ? '0 : r_row;
    assign w_col_last = (w_col == COL_W'(IMG_WIDTH - 1));
    assign w_row_last = (w_row == ROW_W'(IMG_HEIGHT - 1));

    // Read side of the line memories, sampled before this accept's write
    assign w_top = r_lb_top[w_col];
    assign w_mid = r_lb_mid[w_col];

    // Shift every window row left by one byte and append the new column on the right
    assign w_win_next = {s_if.i_pixel, r_win[71:56],
                         w_mid,        r_win[47:32],
                         w_top,        r_win[23:8]};

    assign w_win_valid = (r_state == ST_STREAM) && !w_sof && (w_col >= COL_W'(2));

    // Next raster position and window-state decision for the current accept
    always_comb begin
        w_col_next   = w_col + COL_W'(1);
        w_row_next   = w_row;
        w_state_next = r_state;
        if (w_col_last) begin
            w_col_next = '0;
            w_row_next = w_row_last ? '0 : (w_row + ROW_W'(1));
        end
        if (w_sof) begin
            w_state_next = ST_FILL;
        end else if (r_state == ST_FILL) begin
            if (w_col_last && (w_row == ROW_W'(1))) begin
                w_state_next = ST_STREAM;
            end
        end else begin
            if (w_col_last && w_row_last) begin
                w_state_next = ST_FILL;
            end
        end
    end

    // Counters, FSM state, window register and output strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_FILL;
            r_col       <= '0;
            r_row       <= '0;
            r_win       <= '0;
            r_win_valid <= 1'b0;
`ifdef SOBEL_WIN_FRAME_DONE_EN
            r_frame_done <= 1'b0;
`endif
        end else begin
            r_win_valid <= w_accept & w_win_valid;
`ifdef SOBEL_WIN_FRAME_DONE_EN
            r_frame_done <= w_accept & w_win_valid & w_col_last & w_row_last;
`endif
            if (w_accept) begin
                r_state <= w_state_next;
                r_col   <= w_col_next;
                r_row   <= w_row_next;
                r_win   <= w_win_next;
            end
        end
    end

    // Line memories: mid line ages into top line, new pixel becomes mid line
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_lb_top[w_col] <= w_mid;
            r_lb_mid[w_col] <= s_if.i_pixel;
        end
    end

    assign s_if.o_pixel_data       = r_win;
    assign s_if.o_pixel_data_valid = r_win_valid;
`ifdef SOBEL_WIN_FRAME_DONE_EN
    assign s_if.o_frame_done       = r_frame_done;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Testbench for sobel_window_gen: random raster stimulus against an image-array
// reference model that builds each expected 3x3 window from stored pixels.
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    sobel_window_gen_if bus ();

    sobel_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .s_if    (bus)
    );

    // Reference model state: raster position and the pixels of the current frame
    int          m_row;
    int          m_col;
    logic [7:0]  img [H][W];
    bit          m_have_win;
    logic [71:0] m_last_win;

    int          n_checks;
    int          n_errors;
    int          cnt_win;
    int          cnt_done;
    logic [71:0] first_win;
    logic [71:0] last_win;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [71:0] model_window(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[8*(3*dr+dc) +: 8] = img[r-2+dr][c-2+dc];
        return w;
    endfunction

    // One clock cycle: drive inputs, update the model on the edge, check just after it
    task automatic step(input logic [7:0] pix, input logic vld, input logic sof);
        bit          exp_v;
        bit          exp_done;
        logic [71:0] exp_w;
        exp_v    = 1'b0;
        exp_done = 1'b0;
        exp_w    = '0;
        bus.i_pixel       = pix;
        bus.i_pixel_valid = vld;
        bus.i_sof         = sof;
        @(posedge i_clk);
        if (vld) begin
            if (sof) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = pix;
            exp_v = !sof && (m_row >= 2) && (m_col >= 2);
            if (exp_v) exp_w = model_window(m_row, m_col);
            exp_done = exp_v && (m_row == H-1) && (m_col == W-1);
            if (m_col == W-1) begin
                m_col = 0;
                m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        #1;
        chk("valid", 72'(bus.o_pixel_data_valid), 72'(exp_v));
        if (exp_v) begin
            chk("window", bus.o_pixel_data, exp_w);
            m_have_win = 1'b1;
            m_last_win = exp_w;
        end else if (vld) begin
            m_have_win = 1'b0;
        end else if (m_have_win) begin
            chk("hold", bus.o_pixel_data, m_last_win);
        end
`ifdef SOBEL_WIN_FRAME_DONE_EN
        chk("frame_done", 72'(bus.o_frame_done), 72'(exp_done));
        if (bus.o_frame_done) cnt_done++;
`endif
        if (bus.o_pixel_data_valid) begin
            if (cnt_win == 0) first_win = bus.o_pixel_data;
            last_win = bus.o_pixel_data;
            cnt_win++;
        end
    endtask

    // Stream n pixels; pattern pixels are 8*row+col, otherwise random; optional random gaps
    task automatic send(input int n, input bit pattern, input bit sof_first, input int gap_pct);
        logic [7:0] pix;
        int         k;
        for (int i = 0; i < n; i++) begin
            while ((gap_pct > 0) && ($urandom_range(0, 99) < gap_pct))
                step(8'($urandom), 1'b0, 1'($urandom));
            k   = i % (W*H);
            pix = pattern ? 8'(8*(k/W) + (k%W)) : 8'($urandom);
            step(pix, 1'b1, sof_first && (i == 0));
        end
    endtask

    task automatic do_reset();
        bus.i_pixel_valid = 1'b0;
        bus.i_sof         = 1'b0;
        i_rst_n           = 1'b0;
        #1;
        chk("rst_data", bus.o_pixel_data, 72'h0);
        chk("rst_valid", 72'(bus.o_pixel_data_valid), 72'h0);
        @(posedge i_clk);
        #1;
        chk("rst_data_hold", bus.o_pixel_data, 72'h0);
        i_rst_n    = 1'b1;
        m_row      = 0;
        m_col      = 0;
        m_have_win = 1'b0;
    endtask

    initial begin
        logic [71:0] exp_first;
        logic [71:0] lw;
        exp_first  = 72'h12_11_10_0A_09_08_02_01_00;
        n_checks   = 0;
        n_errors   = 0;
        cnt_win    = 0;
        cnt_done   = 0;
        m_row      = 0;
        m_col      = 0;
        m_have_win = 1'b0;
        bus.i_pixel       = '0;
        bus.i_pixel_valid = 1'b0;
        bus.i_sof         = 1'b0;
        @(negedge i_clk);
        do_reset();

        // Deterministic frame, continuous valid
        cnt_win = 0; cnt_done = 0;
        send(W*H, 1'b1, 1'b1, 0);
        lw = last_win;
        chk("t1_count", 72'(cnt_win), 72'd24);
        chk("t1_first", first_win, exp_first);
        chk("t1_last_br", 72'(lw[71:64]), 72'd47);
`ifdef SOBEL_WIN_FRAME_DONE_EN
        chk("t1_done_cnt", 72'(cnt_done), 72'd1);
`endif

        // Same frame with random input gaps
        cnt_win = 0;
        send(W*H, 1'b1, 1'b1, 50);
        chk("t2_count", 72'(cnt_win), 72'd24);
        chk("t2_first", first_win, exp_first);

        // Two back-to-back random frames, only the first carries sof
        cnt_win = 0; cnt_done = 0;
        send(2*W*H, 1'b0, 1'b1, 20);
        chk("t3_count", 72'(cnt_win), 72'd48);
`ifdef SOBEL_WIN_FRAME_DONE_EN
        chk("t3_done_cnt", 72'(cnt_done), 72'd2);
`endif

        // Frame aborted by sof at pixel (3,4), then a full frame
        cnt_win = 0; cnt_done = 0;
        send(3*W+4, 1'b0, 1'b1, 0);
        chk("t4_partial_count", 72'(cnt_win), 72'd8);
        send(W*H, 1'b0, 1'b1, 0);
        chk("t4_count", 72'(cnt_win), 72'd32);
`ifdef SOBEL_WIN_FRAME_DONE_EN
        chk("t4_done_cnt", 72'(cnt_done), 72'd1);
`endif

        // Reset in the middle of streaming, then a full frame without sof
        send(3*W+6, 1'b0, 1'b1, 0);
        do_reset();
        cnt_win = 0; cnt_done = 0;
        send(W*H, 1'b0, 1'b0, 10);
        chk("t5_count", 72'(cnt_win), 72'd24);
`ifdef SOBEL_WIN_FRAME_DONE_EN
        chk("t5_done_cnt", 72'(cnt_done), 72'd1);
`endif

        step(8'h00, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-to-window stage directly upstream of the 4-direction Sobel edge detector. It accepts a raster-scan stream of 8-bit grayscale pixels and buffers the two previous image lines in line memories. For every pixel that completes a full 3x3 neighbourhood, it emits that neighbourhood as a packed 72-bit word with a valid strobe. The output pair connects directly to the Sobel stage's 72-bit pixel input and its valid input.

## Interface
- IMG_WIDTH, 512, pixels per line (min 3)
- IMG_HEIGHT, 512, lines per frame (min 3)
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- i_pixel  in  8  input pixel, unsigned
- i_pixel_valid  in  1  i_pixel is accepted this cycle
- i_sof  in  1  start of frame; qualified by i_pixel_valid
- o_pixel_data  out  72  3x3 window, byte k = 3*dr + dc
- o_pixel_data_valid  out  1  o_pixel_data holds a new window this cycle

## Operation
- No backpressure. Every cycle with i_pixel_valid=1 accepts one pixel.
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1, each $clog2 wide.
  - On an accept, col increments. At col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - At the last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1), both wrap to 0.
- Line buffers:
  - lb_top and lb_mid are each IMG_WIDTH x 8, not reset.
  - On an accept at column c, read lb_top[c] and lb_mid[c]. Then write lb_top[c] <= old lb_mid[c] and lb_mid[c] <= i_pixel.
- Window register:
  - 3x3 bytes. On each accept, shift columns left by one.
  - The new right column is {lb_top[c], lb_mid[c], i_pixel}, ordered top to bottom.
- Window packing:
  - dr=0 is the top row (row-2) and dc=0 is the left column (col-2).
  - Bits [7:0] hold the top-left pixel. Bits [71:64] hold the current (bottom-right) pixel.
- State machine:
  - FILL (reset state): lines 0-1 of the frame.
  - STREAM: row>=2.
  - FILL -> STREAM on the accept that wraps col to 0 at row=1.
  - STREAM -> FILL on the accept of the last pixel of the frame.
  - Any i_sof accept -> FILL.
- Window valid: a window is valid for an accept when state=STREAM and col>=2. This yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- i_sof with i_pixel_valid=1:
  - The pixel is taken as (0,0), and the counters restart from it.
  - No window is produced for that pixel.
  - This is legal mid-frame: the partial frame is abandoned with no error flag.
- i_sof with i_pixel_valid=0 is ignored.
- Pixels arriving after frame end without i_sof start the next frame at (0,0).
- Input gaps (i_pixel_valid=0) freeze all state. o_pixel_data holds its value and o_pixel_data_valid=0.

## Timing
- Reset values:
  - o_pixel_data=72'h0 and o_pixel_data_valid=0.
  - col=0, row=0, state=FILL, window register all zeros.
- Latency: an accept at cycle N drives o_pixel_data and o_pixel_data_valid at cycle N+1, registered.
- o_pixel_data_valid is a single-cycle strobe per qualifying accept. With back-to-back input it may be high on consecutive cycles.
- Line buffer read-before-write at the same address within one accept; no bypass is needed.
- The first window of a frame appears 1 cycle after accepting pixel (2,2).
- Reset mid-frame clears counters, state and outputs immediately. Stale line buffer contents are never exposed, because the FILL gating applies.

## Configuration
- SOBEL_WIN_FRAME_DONE_EN:
  - When defined, adds output port o_frame_done (1 bit, reset 0).
  - o_frame_done pulses high for one cycle, in the same cycle as the window for the last pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - It does not pulse if the frame is aborted by i_sof.
- When undefined, the port and its logic are absent, and all other behaviour is identical.

## Test plan
- IMG_WIDTH=8, IMG_HEIGHT=6, continuous valid, pixel value = 8*row+col, i_sof on first pixel:
  - Exactly 24 windows.
  - First window = bytes {0,1,2,8,9,10,16,17,18} at k=0..8, one cycle after pixel (2,2).
  - Last window bottom-right byte = 47.
- Same frame with i_pixel_valid toggling 1/0 randomly: identical window sequence, no o_pixel_data_valid during gaps, o_pixel_data stable in gaps.
- Two frames back-to-back without i_sof on the second: 48 windows in total. The second frame's first window is at its pixel (2,2), and no window is emitted at the frame seam.
- i_sof asserted at pixel (3,4) of a frame, then a full frame follows: no window for the sof pixel. The next window appears only after the new (2,2), with contents from the new frame only.
- Assert i_rst_n low mid-STREAM for 1 cycle, then stream a full frame: outputs are 0 during reset and 24 correct windows follow.
- With SOBEL_WIN_FRAME_DONE_EN: o_frame_done is high exactly once per complete frame, coincident with the 24th window, and is never high after an aborted frame.
